apb_cmd_master: RTL and testbench

APB_CMD_MASTER -- requirements
Module: apb_cmd_master

---
 rtl/apb_pkg.sv | 37 +++
 rtl/apb_cmd_master_if.sv | 52 +++++
 rtl/apb_cmd_fifo.sv | 55 +++++
 rtl/apb_cmd_master.sv | 137 +++++++++++++
 tb/tb_apb_cmd_master.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/apb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_pkg: shared types and constants for the APB command master     |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
package apb_pkg;

  localparam int NUM_SLAVES = 4;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int STRB_W     = 4;
  localparam int PROT_W     = 3;
  localparam int SEL_HI     = 31;
  localparam int SEL_LO     = 30;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] strb;
    logic [PROT_W-1:0] prot;
  } apb_cmd_t;

  function automatic logic [NUM_SLAVES-1:0] decode_psel(input logic [SEL_HI-SEL_LO:0] sel);
    decode_psel      = '0;
    decode_psel[sel] = 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/apb_cmd_master_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_cmd_master_if: command, response and APB bus signal bundle     |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
interface apb_cmd_master_if;
  import apb_pkg::*;

  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_W-1:0]     cmd_addr;
  logic                  cmd_write;
  logic [DATA_W-1:0]     cmd_wdata;
  logic [STRB_W-1:0]     cmd_strb;
  logic [PROT_W-1:0]     cmd_prot;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_W-1:0]     rsp_rdata;
  logic                  rsp_slverr;

  logic [NUM_SLAVES-1:0] psel;
  logic                  penable;
  logic [ADDR_W-1:0]     paddr;
  logic                  pwrite;
  logic [PROT_W-1:0]     pprot;
  logic [DATA_W-1:0]     pwdata;
  logic [STRB_W-1:0]     pstrb;
  logic [DATA_W-1:0]     prdata;
  logic                  pready;
  logic                  pslverr;

  modport master (
    input  cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_slverr,
    input  rsp_ready,
    output psel, penable, paddr, pwrite, pprot, pwdata, pstrb,
    input  prdata, pready, pslverr
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_write, cmd_wdata, cmd_strb, cmd_prot,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_slverr,
    output rsp_ready,
    input  psel, penable, paddr, pwrite, pprot, pwdata, pstrb,
    output prdata, pready, pslverr
  );

endinterface
`default_nettype wire

// File: rtl/apb_cmd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_cmd_fifo: power-of-two depth FIFO with full/empty flags        |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module apb_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  wire logic             pclk,
  input  wire logic             preset,
  input  wire logic             push_i,
  input  wire logic [WIDTH-1:0] push_data_i,
  input  wire logic             pop_i,
  output logic      [WIDTH-1:0] head_o,
  output logic                  full_o,
  output logic                  empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i & ~full_o;
  assign do_pop  = pop_i & ~empty_o;

  // Storage carries no reset; only the pointers and count define validity.
  always_ff @(posedge pclk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/apb_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | apb_cmd_master: buffered command stream to APB master bridge       |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module apb_cmd_master
  import apb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input wire logic         pclk,
  input wire logic         preset,
  apb_cmd_master_if.master bus
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  apb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  wait_q, wait_d;
  logic              init_q;
  logic [ADDR_W-1:0] paddr_q;
  logic              pwrite_q;
  logic [PROT_W-1:0] pprot_q;
  logic [DATA_W-1:0] pwdata_q;
  logic [STRB_W-1:0] pstrb_q;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_slverr_q, rsp_slverr_d;

  apb_cmd_t push_data, head;
  logic     fifo_full, fifo_empty, push, pop;

  assign push_data = '{addr: bus.cmd_addr, write: bus.cmd_write, wdata: bus.cmd_wdata,
                       strb: bus.cmd_strb, prot: bus.cmd_prot};
  // init_q keeps cmd_ready low until the first edge after reset release.
  assign bus.cmd_ready = init_q & ~fifo_full;
  assign push          = bus.cmd_valid & bus.cmd_ready;

  apb_cmd_fifo #(
    .WIDTH ($bits(apb_cmd_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .pclk        (pclk),
    .preset      (preset),
    .push_i      (push),
    .push_data_i (push_data),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

  always_comb begin
    state_d      = state_q;
    wait_d       = wait_q;
    pop          = 1'b0;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_slverr_d = rsp_slverr_q;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (bus.pready) begin
          rsp_rdata_d  = pwrite_q ? '0 : bus.prdata;
          rsp_slverr_d = bus.pslverr;
          state_d      = ST_RESP;
        end else begin
          wait_d = wait_q + 1'b1;
          if (wait_d == CNT_W'(TIMEOUT)) begin
            rsp_rdata_d  = '0;
            rsp_slverr_d = 1'b1;
            state_d      = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_SETUP;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (pop) wait_d = '0;
  end

  always_ff @(posedge pclk or negedge preset) begin
    if (!preset) begin
      state_q      <= ST_IDLE;
      wait_q       <= '0;
      init_q       <= 1'b0;
      paddr_q      <= '0;
      pwrite_q     <= 1'b0;
      pprot_q      <= '0;
      pwdata_q     <= '0;
      pstrb_q      <= '0;
      rsp_rdata_q  <= '0;
      rsp_slverr_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      wait_q       <= wait_d;
      init_q       <= 1'b1;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_slverr_q <= rsp_slverr_d;
      if (pop) begin
        paddr_q  <= head.addr;
        pwrite_q <= head.write;
        pprot_q  <= head.prot;
        pwdata_q <= head.wdata;
        pstrb_q  <= head.strb;
      end
    end
  end

  assign bus.psel       = (state_q == ST_SETUP || state_q == ST_ACCESS)
                          ? decode_psel(paddr_q[SEL_HI:SEL_LO]) : '0;
  assign bus.penable    = (state_q == ST_ACCESS);
  assign bus.paddr      = paddr_q;
  assign bus.pwrite     = pwrite_q;
  assign bus.pprot      = pprot_q;
  assign bus.pwdata     = pwdata_q;
  assign bus.pstrb      = pstrb_q;
  assign bus.rsp_valid  = (state_q == ST_RESP);
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign bus.rsp_slverr = rsp_slverr_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_cmd_master.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_apb_cmd_master: directed vector bench for apb_cmd_master        |
// | Rev 1.0 - initial release                                          |
// +--------------------------------------------------------------------+
module tb_apb_cmd_master;

  logic pclk = 1'b0;
  logic preset;
  always #5 pclk = ~pclk;

  apb_cmd_master_if bus();

  apb_cmd_master #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (16)
  ) dut (
    .pclk   (pclk),
    .preset (preset),
    .bus    (bus)
  );

  // Behavioural slave: pready after slv_wait extra ACCESS cycles.
  int          acc_cnt = 0;
  int          slv_wait = 0;
  bit          slv_never = 1'b0;
  bit          slv_err = 1'b0;
  bit          slv_addr_mode = 1'b0;
  logic [31:0] slv_rdata = '0;

  always @(posedge pclk) acc_cnt <= bus.penable ? acc_cnt + 1 : 0;
  assign bus.pready  = bus.penable && (bus.psel != 4'b0) && !slv_never && (acc_cnt >= slv_wait);
  assign bus.pslverr = slv_err && bus.pready;
  assign bus.prdata  = slv_addr_mode ? (bus.paddr ^ 32'hFFFF_0000) : slv_rdata;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive_cmd(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] p);
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_write = w;
    bus.cmd_wdata = d;
    bus.cmd_strb  = s;
    bus.cmd_prot  = p;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          wait_n;
    bit          never;
    bit          err;
    logic [31:0] srdata;
    logic [3:0]  exp_psel;
    int          exp_cyc;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[6];

  logic [31:0] baddr[5] = '{32'h0000_0100, 32'h4000_0200, 32'h8000_0300, 32'hC000_0400, 32'h0000_0500};
  logic [31:0] bexp[5]  = '{32'hFFFF_0100, 32'hBFFF_0200, 32'h7FFF_0300, 32'h3FFF_0400, 32'hFFFF_0500};

  task automatic run_vec(input int i, input vec_t v);
    int n;
    slv_wait  = v.wait_n;
    slv_never = v.never;
    slv_err   = v.err;
    slv_rdata = v.srdata;
    check($sformatf("v%0d_cmd_ready", i), bus.cmd_ready, 1);
    drive_cmd(v.addr, v.wr, v.wdata, v.strb, v.prot);
    tick();
    bus.cmd_valid = 1'b0;
    check($sformatf("v%0d_psel_after_accept", i), bus.psel, 0);
    tick();
    check($sformatf("v%0d_setup_psel", i), bus.psel, v.exp_psel);
    check($sformatf("v%0d_setup_penable", i), bus.penable, 0);
    check($sformatf("v%0d_paddr", i), bus.paddr, v.addr);
    check($sformatf("v%0d_pwrite", i), bus.pwrite, v.wr);
    check($sformatf("v%0d_pwdata", i), bus.pwdata, v.wdata);
    check($sformatf("v%0d_pstrb", i), bus.pstrb, v.strb);
    check($sformatf("v%0d_pprot", i), bus.pprot, v.prot);
    tick();
    check($sformatf("v%0d_access_penable", i), bus.penable, 1);
    check($sformatf("v%0d_access_psel", i), bus.psel, v.exp_psel);
    n = 0;
    while (bus.penable === 1'b1 && n < 64) begin
      n++;
      tick();
    end
    check($sformatf("v%0d_access_cycles", i), n, v.exp_cyc);
    check($sformatf("v%0d_rsp_valid", i), bus.rsp_valid, 1);
    check($sformatf("v%0d_resp_psel", i), bus.psel, 0);
    check($sformatf("v%0d_resp_penable", i), bus.penable, 0);
    check($sformatf("v%0d_rsp_rdata", i), bus.rsp_rdata, v.exp_rdata);
    check($sformatf("v%0d_rsp_slverr", i), bus.rsp_slverr, v.exp_err);
    tick();
    check($sformatf("v%0d_rsp_hold_valid", i), bus.rsp_valid, 1);
    check($sformatf("v%0d_rsp_hold_rdata", i), bus.rsp_rdata, v.exp_rdata);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check($sformatf("v%0d_rsp_done", i), bus.rsp_valid, 0);
    check($sformatf("v%0d_ready_after", i), bus.cmd_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    int viol;

    vecs[0] = '{32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 4'hF, 3'd0, 0, 1'b0, 1'b0, 32'hAAAA_5555, 4'b0001, 1,  32'h0, 1'b0};
    vecs[1] = '{32'h8000_0004, 1'b0, 32'h0,         4'h0, 3'd0, 3, 1'b0, 1'b0, 32'h1234_5678, 4'b0100, 4,  32'h1234_5678, 1'b0};
    vecs[2] = '{32'hC000_0000, 1'b0, 32'h0,         4'h0, 3'd2, 0, 1'b0, 1'b1, 32'hCAFE_0001, 4'b1000, 1,  32'hCAFE_0001, 1'b1};
    vecs[3] = '{32'h4000_0100, 1'b1, 32'h0BAD_F00D, 4'h3, 3'd5, 1, 1'b0, 1'b0, 32'h1111_2222, 4'b0010, 2,  32'h0, 1'b0};
    vecs[4] = '{32'h7FFF_FFFC, 1'b0, 32'h0,         4'h0, 3'd1, 0, 1'b1, 1'b0, 32'h9999_8888, 4'b0010, 16, 32'h0, 1'b1};
    vecs[5] = '{32'h0000_0008, 1'b0, 32'h0,         4'h0, 3'd7, 0, 1'b0, 1'b0, 32'h55AA_33CC, 4'b0001, 1,  32'h55AA_33CC, 1'b0};

    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_write = 1'b0;
    bus.cmd_wdata = '0;
    bus.cmd_strb  = '0;
    bus.cmd_prot  = '0;
    bus.rsp_ready = 1'b0;
    preset = 1'b1;
    #2 preset = 1'b0;
    repeat (3) @(posedge pclk);
    #1;
    check("rst_cmd_ready", bus.cmd_ready, 0);
    check("rst_psel", bus.psel, 0);
    check("rst_penable", bus.penable, 0);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_paddr", bus.paddr, 0);
    check("rst_rsp_rdata", bus.rsp_rdata, 0);
    @(posedge pclk);
    #1 preset = 1'b1;
    check("rel_cmd_ready_before_edge", bus.cmd_ready, 0);
    tick();
    check("rel_cmd_ready_first_edge", bus.cmd_ready, 1);

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Five back-to-back reads with the response held off.
    slv_addr_mode = 1'b1;
    slv_wait = 0; slv_never = 1'b0; slv_err = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("burst_ready_%0d", k), bus.cmd_ready, 1);
      drive_cmd(baddr[k], 1'b0, 32'h0, 4'h0, 3'd0);
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("burst_full", bus.cmd_ready, 0);
    check("burst_first_resp", bus.rsp_valid, 1);
    tick();
    check("burst_still_full", bus.cmd_ready, 0);
    bus.rsp_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 100 && got < 5; c++) begin
      if (bus.rsp_valid) begin
        check($sformatf("burst_rdata_%0d", got), bus.rsp_rdata, bexp[got]);
        check($sformatf("burst_slverr_%0d", got), bus.rsp_slverr, 0);
        got++;
      end
      tick();
    end
    bus.rsp_ready = 1'b0;
    check("burst_resp_count", got, 5);
    check("burst_end_idle_psel", bus.psel, 0);
    check("burst_end_rsp_valid", bus.rsp_valid, 0);
    check("burst_end_ready", bus.cmd_ready, 1);
    slv_addr_mode = 1'b0;

    // Reset during ACCESS with two commands queued.
    slv_never = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_cmd(32'h4000_0000 + 32'(k * 4), 1'b0, 32'h0, 4'h0, 3'd0);
      tick();
    end
    bus.cmd_valid = 1'b0;
    check("rstmid_in_access", bus.penable, 1);
    check("rstmid_psel", bus.psel, 4'b0010);
    #2 preset = 1'b0;
    #1;
    check("rstmid_psel_zero", bus.psel, 0);
    check("rstmid_penable_zero", bus.penable, 0);
    check("rstmid_cmd_ready_zero", bus.cmd_ready, 0);
    check("rstmid_rsp_valid_zero", bus.rsp_valid, 0);
    check("rstmid_paddr_zero", bus.paddr, 0);
    @(posedge pclk);
    #1 preset = 1'b1;
    slv_never = 1'b0;
    bus.rsp_ready = 1'b1;
    check("rstmid_ready_before_edge", bus.cmd_ready, 0);
    tick();
    check("rstmid_ready_after_edge", bus.cmd_ready, 1);
    viol = 0;
    repeat (30) begin
      if (bus.rsp_valid !== 1'b0 || bus.psel !== 4'b0) viol++;
      tick();
    end
    check("rstmid_no_activity", viol, 0);
    bus.rsp_ready = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
